// File: rtl/bidir_io_bank.sv
// bidir_io_bank: WIDTH tri-state pads with a registered output path, an input
// synchroniser and a direction FSM that keeps the pads released (Z) for
// TURN_CYCLES dead cycles at every bus turnaround.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// INPUT    | pads Z, settle counter runs down, in_valid once it reaches 0
// TURN_OUT | pads Z, dead time before driving
// DRIVE    | pads driven from the output register, drive_ack=1
// TURN_IN  | pads Z, dead time before the external device may drive
module bidir_io_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  inout  wire  [WIDTH-1:0] pad,
  input  logic             drive_req,
  output logic             drive_ack,
  input  logic [WIDTH-1:0] dout,
  input  logic             dout_we,
  output logic [WIDTH-1:0] din,
  output logic             in_valid,
  output logic             in_change
);

  // din_q acts as the final synchroniser stage, so the chain itself is one short
  localparam int CHAIN = SYNC_STAGES - 1;
  localparam int CW    = 5;
  localparam logic [CW-1:0] TURN_CNT   = CW'(TURN_CYCLES);
  localparam logic [CW-1:0] SETTLE_CNT = CW'(TURN_CYCLES + SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_TURN_IN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             oe_q, oe_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] din_q, din_d;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] sync_q [CHAIN];

  // State and shared turnaround/settle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INPUT;
      cnt_q   <= SETTLE_CNT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: every path into DRIVE passes through TURN_OUT's full dead time
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INPUT: begin
        if (drive_req) begin
          state_d = ST_TURN_OUT;
          cnt_d   = TURN_CNT;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_TURN_OUT: begin
        if (!drive_req) begin
          state_d = ST_INPUT;
          cnt_d   = SETTLE_CNT;
        end else if (cnt_q <= CW'(1)) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRIVE: begin
        if (!drive_req) begin
          state_d = ST_TURN_IN;
          cnt_d   = TURN_CNT;
        end
      end
      ST_TURN_IN: begin
        if (drive_req) begin
          state_d = ST_TURN_OUT;
          cnt_d   = TURN_CNT;
        end else if (cnt_q <= CW'(1)) begin
          state_d = ST_INPUT;
          cnt_d   = SETTLE_CNT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_INPUT;
        cnt_d   = SETTLE_CNT;
      end
    endcase
  end

  // Outputs decoded from the next state so they can be registered glitch-free
  always_comb begin
    oe_d    = (state_d == ST_DRIVE);
    valid_d = (state_d == ST_INPUT) && (cnt_d == '0);
  end

  // Registered output enable and input-valid flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      oe_q    <= oe_d;
      valid_q <= valid_d;
    end
  end

  // Output data register, writable in any state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
    end else if (dout_we) begin
      out_q <= dout;
    end
  end

  // Synchroniser chain always samples the pads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHAIN; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad;
      for (int i = 1; i < CHAIN; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // din follows the last stage only while input data is trusted
  always_comb begin
    din_d = din_q;
    chg_d = 1'b0;
    if (valid_q) begin
      din_d = sync_q[CHAIN-1];
      chg_d = (sync_q[CHAIN-1] != din_q);
    end
  end

  // Held input value and change pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_q <= '0;
      chg_q <= 1'b0;
    end else begin
      din_q <= din_d;
      chg_q <= chg_d;
    end
  end

  assign pad       = oe_q ? out_q : {WIDTH{1'bz}};
  assign drive_ack = oe_q;
  assign din       = din_q;
  assign in_valid  = valid_q;
  assign in_change = chg_q;

endmodule
